dtw_core_ctrl: RTL and testbench

Sequencing and compute core directly downstream of the DTW AXI4-Lite register slave. It consumes the control word (`dtw_cr`) and reference length (`dtw_ref_len`), and streams query samples in. For each sample it sweeps the reference memory and updates a subsequence-DTW cost column held in an internal dual-port buffer. It returns the minimum final-row cost on a result stream and reports progress through `dtw_sr`.

---
 rtl/dtw_core_ctrl_if.sv | 27 ++
 rtl/dtw_core_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_dtw_core_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/dtw_core_ctrl_if.sv
// Stream and memory bundle of dtw_core_ctrl: query samples in, reference-memory read port, result stream out.
// The master modport is the core side; the slave modport is the surrounding fabric.
interface dtw_core_ctrl_if #(
  parameter int SAMPLE_WIDTH   = 16,
  parameter int REF_ADDR_WIDTH = 15,
  parameter int COST_WIDTH     = 32
);
  logic [SAMPLE_WIDTH-1:0]   q_tdata;
  logic                      q_tvalid;
  logic                      q_tready;
  logic [REF_ADDR_WIDTH-1:0] ref_addr;
  logic                      ref_rd_en;
  logic [SAMPLE_WIDTH-1:0]   ref_rdata;
  logic [COST_WIDTH-1:0]     res_tdata;
  logic                      res_tvalid;
  logic                      res_tready;

  modport master (
    input  q_tdata, q_tvalid, ref_rdata, res_tready,
    output q_tready, ref_addr, ref_rd_en, res_tdata, res_tvalid
  );

  modport slave (
    output q_tdata, q_tvalid, ref_rdata, res_tready,
    input  q_tready, ref_addr, ref_rd_en, res_tdata, res_tvalid
  );
endinterface

// File: rtl/dtw_core_ctrl.sv
// Subsequence-DTW sequencer/compute core: sweeps the reference per query sample and keeps one cost column.
// Optional feature macro: DTW_CTRL_IRQ_EN (registered completion interrupt gated by dtw_cr[2]).
module dtw_core_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int SAMPLE_WIDTH   = 16,
  parameter int REF_ADDR_WIDTH = 15,
  parameter int COST_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] dtw_cr,
  input  logic [DATA_WIDTH-1:0] dtw_ref_len,
  output logic [DATA_WIDTH-1:0] dtw_sr,
  dtw_core_ctrl_if.master       bus,
  output logic                  irq
);

  localparam int LW    = REF_ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << REF_ADDR_WIDTH;
  localparam logic [DATA_WIDTH-1:0] MAX_LEN = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << REF_ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT_Q = 3'd1,
    ST_SWEEP  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  function automatic logic [COST_WIDTH-1:0] sat_add(input logic [COST_WIDTH-1:0] a,
                                                    input logic [COST_WIDTH-1:0] b);
    logic [COST_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[COST_WIDTH]) begin
      sat_add = {COST_WIDTH{1'b1}};
    end else begin
      sat_add = sum[COST_WIDTH-1:0];
    end
  endfunction

  state_t                    state_r, state_nx_s;
  logic                      start_d_r, busy_r, done_r, aborted_r, error_r;
  logic [LW-1:0]             len_r, len_m1_s;
  logic [15:0]               qlen_r, count_r;
  logic [SAMPLE_WIDTH-1:0]   q_r;
  logic [REF_ADDR_WIDTH-1:0] ref_addr_r, cell_addr_r;
  logic                      ref_rd_en_r, q_tready_r, res_tvalid_r;
  logic [COST_WIDTH-1:0]     res_tdata_r;
  logic                      cell_vld_r, cell_j0_r;
  logic [COST_WIDTH-1:0]     p_prev_r, d_prev_r, min_r, col_rdata_r;
  logic [COST_WIDTH-1:0]     col_mem [DEPTH];

  logic                      start_edge_s, cfg_bad_s, accept_s, cfg_err_s;
  logic                      q_hs_s, res_hs_s, abort_s, first_row_s, last_row_s;
  logic [SAMPLE_WIDTH-1:0]   diff_s;
  logic [COST_WIDTH-1:0]     d_s, min_p_s, min3_s, cost_s, min_nx_s;
  logic [DATA_WIDTH-1:0]     sr_s;
  logic                      unused_bits_s;

  assign start_edge_s = dtw_cr[0] & ~start_d_r;
  assign cfg_bad_s    = (dtw_ref_len == {DATA_WIDTH{1'b0}}) | (dtw_ref_len > MAX_LEN) |
                        (dtw_cr[31:16] == 16'd0);
  assign len_m1_s     = len_r - {{(LW-1){1'b0}}, 1'b1};
  assign first_row_s  = (count_r == 16'd1);
  assign last_row_s   = (count_r == qlen_r);

  // Next-state decode and one-cycle strobes; abort outranks every non-idle transition.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    cfg_err_s  = 1'b0;
    q_hs_s     = 1'b0;
    res_hs_s   = 1'b0;
    abort_s    = 1'b0;
    if ((state_r != ST_IDLE) && dtw_cr[1]) begin
      abort_s    = 1'b1;
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_edge_s) begin
            accept_s = 1'b1;
            if (cfg_bad_s) begin
              cfg_err_s  = 1'b1;
              state_nx_s = ST_IDLE;
            end else begin
              state_nx_s = ST_WAIT_Q;
            end
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_WAIT_Q: begin
          if (bus.q_tvalid) begin
            q_hs_s     = 1'b1;
            state_nx_s = ST_SWEEP;
          end else begin
            state_nx_s = ST_WAIT_Q;
          end
        end
        ST_SWEEP: begin
          if (ref_addr_r == len_m1_s[REF_ADDR_WIDTH-1:0]) begin
            state_nx_s = ST_DRAIN;
          end else begin
            state_nx_s = ST_SWEEP;
          end
        end
        ST_DRAIN: begin
          if (count_r < qlen_r) begin
            state_nx_s = ST_WAIT_Q;
          end else begin
            state_nx_s = ST_RESULT;
          end
        end
        ST_RESULT: begin
          if (bus.res_tready) begin
            res_hs_s   = 1'b1;
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_RESULT;
          end
        end
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // Control state, run configuration, sticky flags and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      start_d_r    <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      aborted_r    <= 1'b0;
      error_r      <= 1'b0;
      len_r        <= {LW{1'b0}};
      qlen_r       <= 16'd0;
      count_r      <= 16'd0;
      q_r          <= {SAMPLE_WIDTH{1'b0}};
      ref_addr_r   <= {REF_ADDR_WIDTH{1'b0}};
      ref_rd_en_r  <= 1'b0;
      q_tready_r   <= 1'b0;
      res_tvalid_r <= 1'b0;
      res_tdata_r  <= {COST_WIDTH{1'b0}};
    end else begin
      state_r      <= state_nx_s;
      start_d_r    <= dtw_cr[0];
      busy_r       <= (state_nx_s != ST_IDLE);
      q_tready_r   <= (state_nx_s == ST_WAIT_Q);
      ref_rd_en_r  <= (state_nx_s == ST_SWEEP);
      res_tvalid_r <= (state_nx_s == ST_RESULT);
      if (accept_s) begin
        len_r     <= dtw_ref_len[LW-1:0];
        qlen_r    <= dtw_cr[31:16];
        count_r   <= 16'd0;
        done_r    <= cfg_err_s;
        error_r   <= cfg_err_s;
        aborted_r <= 1'b0;
      end else begin
        if (q_hs_s) count_r <= count_r + 16'd1;
        if (res_hs_s) done_r <= 1'b1;
        if (abort_s) aborted_r <= 1'b1;
      end
      if (q_hs_s) begin
        q_r        <= bus.q_tdata;
        ref_addr_r <= {REF_ADDR_WIDTH{1'b0}};
      end else if ((state_r == ST_SWEEP) && (state_nx_s == ST_SWEEP)) begin
        ref_addr_r <= ref_addr_r + {{(REF_ADDR_WIDTH-1){1'b0}}, 1'b1};
      end
      if ((state_r == ST_DRAIN) && (state_nx_s == ST_RESULT)) res_tdata_r <= min_nx_s;
    end
  end

  // Cell cost: P(j) arrives from the column read, P(j-1)/D(j-1) from the previous cell.
  always_comb begin
    diff_s   = {SAMPLE_WIDTH{1'b0}};
    min_p_s  = p_prev_r;
    min3_s   = d_prev_r;
    cost_s   = {COST_WIDTH{1'b0}};
    min_nx_s = min_r;
    if (q_r >= bus.ref_rdata) begin
      diff_s = q_r - bus.ref_rdata;
    end else begin
      diff_s = bus.ref_rdata - q_r;
    end
    d_s = COST_WIDTH'(diff_s);
    if (col_rdata_r < p_prev_r) min_p_s = col_rdata_r; else min_p_s = p_prev_r;
    if (d_prev_r < min_p_s) min3_s = d_prev_r; else min3_s = min_p_s;
    if (first_row_s) begin
      cost_s = d_s;
    end else if (cell_j0_r) begin
      cost_s = sat_add(d_s, col_rdata_r);
    end else begin
      cost_s = sat_add(d_s, min3_s);
    end
    if (cell_vld_r && last_row_s && (cell_j0_r || (cost_s < min_r))) begin
      min_nx_s = cost_s;
    end else begin
      min_nx_s = min_r;
    end
  end

  // Cell pipeline stage one cycle behind the address issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      cell_vld_r  <= 1'b0;
      cell_j0_r   <= 1'b0;
      cell_addr_r <= {REF_ADDR_WIDTH{1'b0}};
      p_prev_r    <= {COST_WIDTH{1'b0}};
      d_prev_r    <= {COST_WIDTH{1'b0}};
      min_r       <= {COST_WIDTH{1'b0}};
    end else begin
      cell_vld_r  <= ref_rd_en_r;
      cell_j0_r   <= (ref_addr_r == {REF_ADDR_WIDTH{1'b0}});
      cell_addr_r <= ref_addr_r;
      min_r       <= min_nx_s;
      if (cell_vld_r) begin
        p_prev_r <= col_rdata_r;
        d_prev_r <= cost_s;
      end
    end
  end

  // Column buffer: read j+1 and write j never collide, so no bypass path exists.
  always_ff @(posedge clk) begin
    if (ref_rd_en_r) col_rdata_r <= col_mem[ref_addr_r];
    if (cell_vld_r) col_mem[cell_addr_r] <= cost_s;
  end

  // Status word assembled from registered flags.
  always_comb begin
    sr_s        = {DATA_WIDTH{1'b0}};
    sr_s[0]     = busy_r;
    sr_s[1]     = done_r;
    sr_s[2]     = aborted_r;
    sr_s[3]     = error_r;
    sr_s[31:16] = count_r;
  end

  assign dtw_sr         = sr_s;
  assign bus.q_tready   = q_tready_r;
  assign bus.ref_addr   = ref_addr_r;
  assign bus.ref_rd_en  = ref_rd_en_r;
  assign bus.res_tvalid = res_tvalid_r;
  assign bus.res_tdata  = res_tdata_r;
  assign unused_bits_s  = ^{dtw_cr[15:2], len_m1_s[LW-1]};

`ifdef DTW_CTRL_IRQ_EN
  logic irq_r;

  // One-cycle pulse on the cycle done becomes set, when enabled by the control word.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= (res_hs_s | cfg_err_s) & dtw_cr[2];
    end
  end

  assign irq = irq_r;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_dtw_core_ctrl.sv
// Directed plus randomized bench for dtw_core_ctrl; expected costs come from a full-matrix DTW model.
module tb_dtw_core_ctrl;
  localparam int DW = 32, SW = 16, AW = 4, CW = 16, DEPTH = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] dtw_cr, dtw_ref_len, dtw_sr;
  logic          irq;
  logic [SW-1:0] ref_mem [DEPTH];
  int            qv [8];
  int            total = 0, bad = 0, irq_cnt = 0, irq_exp = 0;

  dtw_core_ctrl_if #(.SAMPLE_WIDTH(SW), .REF_ADDR_WIDTH(AW), .COST_WIDTH(CW)) bus ();

  dtw_core_ctrl #(.DATA_WIDTH(DW), .SAMPLE_WIDTH(SW), .REF_ADDR_WIDTH(AW), .COST_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .dtw_cr(dtw_cr), .dtw_ref_len(dtw_ref_len),
    .dtw_sr(dtw_sr), .bus(bus), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ref_rd_en) bus.ref_rdata <= ref_mem[bus.ref_addr];
  end

  always @(negedge clk) begin
    if (irq) irq_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole-matrix subsequence DTW with saturating sums; returns min over the last row.
  function automatic int model(input int L, input int Q);
    int unsigned D [8][16];
    int unsigned d, m, best;
    for (int i = 0; i < Q; i++) begin
      for (int j = 0; j < L; j++) begin
        d = (qv[i] > int'(ref_mem[j])) ? qv[i] - int'(ref_mem[j]) : int'(ref_mem[j]) - qv[i];
        if (i == 0) begin
          D[i][j] = d;
        end else begin
          m = D[i-1][j];
          if (j > 0) begin
            if (D[i-1][j-1] < m) m = D[i-1][j-1];
            if (D[i][j-1] < m) m = D[i][j-1];
          end
          D[i][j] = (d + m > CMAX) ? CMAX : d + m;
        end
      end
    end
    best = D[Q-1][0];
    for (int j = 1; j < L; j++) if (D[Q-1][j] < best) best = D[Q-1][j];
    return int'(best);
  endfunction

  function automatic int irq_expected(input logic ien);
`ifdef DTW_CTRL_IRQ_EN
    return int'(ien);
`else
    return 0;
`endif
  endfunction

  task automatic do_start(input int L, input int Q, input logic ien);
    logic [15:0] q16;
    q16 = 16'(Q);
    dtw_ref_len = DW'(L);
    dtw_cr = {q16, 13'd0, ien, 2'b01};
    @(negedge clk);
    dtw_cr[0] = 1'b0;
  endtask

  task automatic send(input logic [SW-1:0] v, output int w);
    bus.q_tdata  = v;
    bus.q_tvalid = 1'b1;
    w = 0;
    while (!bus.q_tready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("q_wait_bound", 32'(w < 100), 32'd1);
    @(negedge clk);
    bus.q_tvalid = 1'b0;
  endtask

  task automatic get_result(input logic [CW-1:0] expv, input int Q, input int stall, input logic ien);
    int w;
    int e;
    w = 0;
    e = irq_expected(ien);
    bus.res_tready = 1'b0;
    while (!bus.res_tvalid && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("res_valid", 32'(bus.res_tvalid), 32'd1);
    chk("res_data", 32'(bus.res_tdata), 32'(expv));
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("stall_hold", 32'({bus.res_tvalid, dtw_sr[1], bus.res_tdata}), 32'({1'b1, 1'b0, expv}));
    end
    bus.res_tready = 1'b1;
    @(negedge clk);
    bus.res_tready = 1'b0;
    chk("post_flags", 32'({dtw_sr[3:0], bus.res_tvalid}), 32'({4'b0010, 1'b0}));
    chk("post_count", 32'(dtw_sr[31:16]), 32'(Q));
    chk("post_irq", 32'(irq), 32'(e));
    irq_exp += e;
    @(negedge clk);
    chk("irq_width", 32'(irq), 32'd0);
  endtask

  initial begin
    int w, L, Q, seen, res;
    logic ien;
    rst = 1'b1;
    dtw_cr = '0;
    dtw_ref_len = '0;
    bus.q_tdata = '0;
    bus.q_tvalid = 1'b0;
    bus.res_tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_sr", dtw_sr, 32'd0);
    chk("reset_outs", 32'({bus.q_tready, bus.ref_rd_en, bus.res_tvalid, irq}), 32'd0);
    chk("reset_addr", 32'(bus.ref_addr), 32'd0);
    chk("reset_tdata", 32'(bus.res_tdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reference [10,20,30,40], queries 21 then 29, with a stalled result.
    ref_mem[0] = 16'd10; ref_mem[1] = 16'd20; ref_mem[2] = 16'd30; ref_mem[3] = 16'd40;
    do_start(4, 2, 1'b1);
    chk("start_latency", 32'({dtw_sr[0], bus.q_tready}), 32'd3);
    send(16'd21, w);
    send(16'd29, w);
    chk("sample_period", 32'(w), 32'd5);
    dtw_cr[0] = 1'b1;
    @(negedge clk);
    dtw_cr[0] = 1'b0;
    get_result(16'd2, 2, 10, 1'b1);

    for (int i = 0; i < 4; i++) ref_mem[i] = 16'd0;
    do_start(4, 1, 1'b0);
    chk("start_latency2", 32'({dtw_sr[0], bus.q_tready}), 32'd3);
    send(16'd5, w);
    get_result(16'd5, 1, 0, 1'b0);

    // Rejected configurations: zero length, zero query length, oversize length.
    for (int t = 0; t < 3; t++) begin
      L = (t == 0) ? 0 : (t == 1) ? 4 : DEPTH + 1;
      Q = (t == 1) ? 0 : 1;
      do_start(L, Q, 1'b1);
      chk("err_flags", 32'(dtw_sr[3:0]), 32'b1010);
      chk("err_irq", 32'(irq), 32'(irq_expected(1'b1)));
      irq_exp += irq_expected(1'b1);
      seen = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (bus.q_tready || bus.ref_rd_en) seen++;
      end
      chk("err_quiet", 32'(seen), 32'd0);
    end

    // Abort in the middle of a sweep.
    for (int i = 0; i < 8; i++) ref_mem[i] = 16'($urandom_range(0, 500));
    do_start(8, 2, 1'b1);
    send(16'd7, w);
    repeat (2) @(negedge clk);
    dtw_cr[1] = 1'b1;
    @(negedge clk);
    dtw_cr[1] = 1'b0;
    chk("abort_flags", 32'(dtw_sr[3:0]), 32'b0100);
    chk("abort_outs", 32'({bus.q_tready, bus.ref_rd_en, bus.res_tvalid}), 32'd0);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.res_tvalid) seen++;
    end
    chk("abort_no_result", 32'(seen), 32'd0);

    // Reset mid-run.
    do_start(6, 1, 1'b0);
    send(16'd3, w);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_sr", dtw_sr, 32'd0);
    chk("midrst_outs", 32'({bus.q_tready, bus.ref_rd_en, bus.res_tvalid, bus.ref_addr}), 32'd0);

    // Saturating cost.
    ref_mem[0] = 16'd0; ref_mem[1] = 16'd0;
    do_start(2, 2, 1'b0);
    send(16'hFFFF, w);
    send(16'hFFFF, w);
    get_result(16'hFFFF, 2, 0, 1'b0);

    // Random runs, the first at full reference length.
    for (int r = 0; r < 8; r++) begin
      L = (r == 0) ? DEPTH : $urandom_range(1, DEPTH);
      Q = $urandom_range(1, 4);
      ien = 1'($urandom_range(0, 1));
      for (int j = 0; j < L; j++)
        ref_mem[j] = (r == 7) ? 16'($urandom_range(60000, 65535)) : 16'($urandom_range(0, 4000));
      for (int i = 0; i < Q; i++) qv[i] = (r == 7) ? $urandom_range(0, 100) : $urandom_range(0, 4000);
      res = model(L, Q);
      do_start(L, Q, ien);
      for (int i = 0; i < Q; i++) send(16'(qv[i]), w);
      get_result(16'(res), Q, $urandom_range(0, 3), ien);
    end

    repeat (2) @(negedge clk);
    chk("irq_count", 32'(irq_cnt), 32'(irq_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
